// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate sequencer: FSM state type, vector count
// and the reference function for the 2-input gate under test (XOR).
package gate_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int NUM_VEC = 4;
  localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

  // Expected response of a healthy gate for stimulus (a, b).
  function automatic logic exp_out(input logic a, input logic b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Dwell down-counter: load a value, count down while enabled, flag zero.
module gate_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gate_seq_ctrl.sv
// Gate sequencer: sweeps vectors 00,01,10,11 into a 2-input gate, holds
// each for D=max(dwell,1) cycles, samples the response and counts mismatches
// against XOR. Optional macro GATE_SEQ_LOOP_EN adds a 'stop' input and
// continuous sweeping until stop is seen during a sweep.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef GATE_SEQ_LOOP_EN
  input  logic               stop,
`endif
  input  logic [DWELL_W-1:0] dwell,
  output logic               gate_a,
  output logic               gate_b,
  input  logic               gate_y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err_cnt,
  output logic [1:0]         fail_vec
);

  state_e             state_q, state_d;
  logic [1:0]         vec_q, vec_d;
  logic [DWELL_W-1:0] dm1_q, dm1_d;      // D-1, reload value per vector
  logic               gate_a_q, gate_a_d;
  logic               gate_b_q, gate_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [2:0]         err_q, err_d;
  logic [1:0]         fvec_q, fvec_d;
  logic               tmr_load_s, tmr_en_s, tmr_zero_s;
  logic [DWELL_W-1:0] tmr_val_s;
  logic               mismatch_s;
  logic [DWELL_W-1:0] dwell_m1_s;
`ifdef GATE_SEQ_LOOP_EN
  logic               stop_q, stop_d;
`endif

  gate_seq_timer #(.W(DWELL_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  assign dwell_m1_s = (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : (dwell - DWELL_W'(1));
  assign mismatch_s = (gate_y != exp_out(gate_a_q, gate_b_q));

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    dm1_d      = dm1_q;
    gate_a_d   = gate_a_q;
    gate_b_d   = gate_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    fvec_d     = fvec_q;
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = dm1_q;
`ifdef GATE_SEQ_LOOP_EN
    stop_d     = stop_q | stop;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_APPLY;
          busy_d     = 1'b1;
          dm1_d      = dwell_m1_s;
          err_d      = 3'd0;
          pass_d     = 1'b0;
          fvec_d     = 2'd0;
          vec_d      = 2'd0;
          gate_a_d   = 1'b0;
          gate_b_d   = 1'b0;
          tmr_load_s = 1'b1;
          tmr_val_s  = dwell_m1_s;
`ifdef GATE_SEQ_LOOP_EN
          stop_d     = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        // Timer holds D-1 on entry, so zero marks the last APPLY cycle.
        if (tmr_zero_s) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_s) begin
          err_d = err_q + 3'd1;
          if (err_q == 3'd0) begin
            fvec_d = vec_q;
          end else begin
            fvec_d = fvec_q;
          end
        end else begin
          err_d = err_q;
        end
        if (vec_q == LAST_VEC) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = (err_d == 3'd0);
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
        end else begin
          state_d    = ST_APPLY;
          vec_d      = vec_q + 2'd1;
          gate_a_d   = vec_d[1];
          gate_b_d   = vec_d[0];
          tmr_load_s = 1'b1;
        end
      end
      ST_DONE: begin
`ifdef GATE_SEQ_LOOP_EN
        if (stop_q | stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_APPLY;
          busy_d     = 1'b1;
          err_d      = 3'd0;
          fvec_d     = 2'd0;
          vec_d      = 2'd0;
          gate_a_d   = 1'b0;
          gate_b_d   = 1'b0;
          tmr_load_s = 1'b1;
          stop_d     = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        gate_a_d = 1'b0;
        gate_b_d = 1'b0;
      end
    endcase
  end

  // Register all FSM state and outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vec_q    <= 2'd0;
      dm1_q    <= {DWELL_W{1'b0}};
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 3'd0;
      fvec_q   <= 2'd0;
`ifdef GATE_SEQ_LOOP_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      dm1_q    <= dm1_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvec_q   <= fvec_d;
`ifdef GATE_SEQ_LOOP_EN
      stop_q   <= stop_d;
`endif
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fvec_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl. The gate under test is modelled here as
// a correct XOR, a stuck-at-0 output, or an XNOR, selected by gate_mode.
module tb_gate_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic       gate_a, gate_b, gate_y, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  int         gate_mode = 0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign gate_y = (gate_mode == 0) ? (gate_a ^ gate_b) :
                  (gate_mode == 1) ? 1'b0 : ~(gate_a ^ gate_b);

  gate_seq_ctrl #(.DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef GATE_SEQ_LOOP_EN
    .stop     (stop),
`endif
    .dwell    (dwell),
    .gate_a   (gate_a),
    .gate_b   (gate_b),
    .gate_y   (gate_y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    #12;
    obs = {gate_a, gate_b, busy, done, pass, err_cnt};
    checks++;
    if (obs !== 8'd0 || fail_vec !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b expected 0/0", obs, fail_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One sweep; edge 1 is the edge that samples start. Vectors and busy are
  // checked every cycle until the done pulse, then the final results.
  task automatic do_sweep(input string nm, input int dw, input int mode,
                          input int mid_start_at, input int exp_done_at,
                          input logic [2:0] exp_err, input logic [1:0] exp_fail,
                          input logic exp_pass);
    int d;
    int done_at;
    bit seen;
    logic [1:0] exp_vec;
    d = (dw == 0) ? 1 : dw;
    gate_mode = mode;
    @(negedge clk);
    dwell = dw[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 80 && !seen; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      start = (k == mid_start_at);
      if (done) begin
        seen = 1'b1;
        done_at = k;
      end else if (k - 1 < 4 * (d + 1)) begin
        exp_vec = 2'((k - 1) / (d + 1));
        checks++;
        if ({gate_a, gate_b} !== exp_vec || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_vec@%0d: got ab=%b busy=%b expected ab=%b busy=1",
                   nm, k, {gate_a, gate_b}, busy, exp_vec);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (done_at != exp_done_at) begin
      errors++;
      $display("FAIL %s_done_time: got %0d expected %0d", nm, done_at, exp_done_at);
    end
    checks++;
    if (err_cnt !== exp_err || fail_vec !== exp_fail || pass !== exp_pass ||
        busy !== 1'b0 || {gate_a, gate_b} !== 2'b00) begin
      errors++;
      $display("FAIL %s_result: got err=%0d fv=%0d pass=%b busy=%b ab=%b expected err=%0d fv=%0d pass=%b busy=0 ab=00",
               nm, err_cnt, fail_vec, pass, busy, {gate_a, gate_b}, exp_err, exp_fail, exp_pass);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err_cnt !== exp_err || fail_vec !== exp_fail || pass !== exp_pass) begin
      errors++;
      $display("FAIL %s_hold: got done=%b err=%0d fv=%0d pass=%b expected done=0 err=%0d fv=%0d pass=%b",
               nm, done, err_cnt, fail_vec, pass, exp_err, exp_fail, exp_pass);
    end
  endtask

  task automatic test_xor_ok();
    do_sweep("xor_d3", 3, 0, 0, 17, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_stuck0();
    do_sweep("stuck0", 3, 1, 0, 17, 3'd2, 2'd1, 1'b0);
  endtask

  task automatic test_xnor();
    do_sweep("xnor", 2, 2, 0, 13, 3'd4, 2'd0, 1'b0);
  endtask

  task automatic test_dwell_zero();
    do_sweep("dwell0", 0, 0, 0, 9, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_mid_start();
    do_sweep("midstart", 3, 0, 6, 17, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] obs;
    gate_mode = 2;
    @(negedge clk);
    dwell = 8'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gate_a, gate_b, busy, done, pass, err_cnt};
    checks++;
    if (obs !== 8'd0 || fail_vec !== 2'd0) begin
      errors++;
      $display("FAIL midreset_async: got %b/%b expected 0/0", obs, fail_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep("after_reset", 3, 0, 0, 17, 3'd0, 2'd0, 1'b1);
  endtask

`ifdef GATE_SEQ_LOOP_EN
  task automatic test_loop();
    int ndone;
    gate_mode = 0;
    ndone = 0;
    @(negedge clk);
    dwell = 8'd1;
    stop = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      stop = (k == 12);
      if (done) ndone++;
      if (k == 9 || k == 18) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL loop_done@%0d: got %b expected 1", k, done);
        end
      end
    end
    stop = 1'b0;
    checks++;
    if (ndone != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: got dones=%0d busy=%b expected dones=2 busy=0", ndone, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_xor_ok();
    test_stuck0();
    test_xnor();
    test_dwell_zero();
    test_mid_start();
    test_mid_reset();
`ifdef GATE_SEQ_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
GATE_SEQ_CTRL -- requirements
Module: gate_seq_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of dwell count.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, launches one sweep when sampled high in IDLE.
REQ-005 SHALL have port dwell, input, DWELL_W, APPLY-phase length in cycles, sampled at start.
REQ-006 SHALL have ports gate_a and gate_b, output, 1 each, registered stimulus to the 2-input gate under test.
REQ-007 SHALL have port gate_y, input, 1, response of the gate under test, combinational from gate_a/gate_b.
REQ-008 SHALL have port busy, output, 1, high in APPLY and SAMPLE.
REQ-009 SHALL have port done, output, 1, single-cycle pulse at sweep end.
REQ-010 SHALL have port pass, output, 1, high when the last sweep had zero mismatches.
REQ-011 SHALL have port err_cnt, output, 3, mismatch count of the current or last sweep.
REQ-012 SHALL have port fail_vec, output, 2, index of the first mismatching vector.

Function
REQ-013 SHALL implement states IDLE, APPLY, SAMPLE, DONE.
REQ-014 SHALL apply vectors {gate_a,gate_b} = 00, 01, 10, 11 in order (index 0..3).
REQ-015 SHALL, in IDLE with start=1, latch D = max(dwell,1), clear err_cnt, pass and fail_vec, drive vector 0, and enter APPLY on the next edge.
REQ-016 SHALL hold each vector for D cycles in APPLY, then one cycle in SAMPLE; per-vector period is D+1 cycles.
REQ-017 SHALL, in SAMPLE, compare gate_y to gate_a XOR gate_b; on mismatch, increment err_cnt and, if this is the first mismatch, load fail_vec with the vector index.
REQ-018 SHALL, after SAMPLE of vector 0..2, drive the next vector and re-enter APPLY; after vector 3, enter DONE.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, set pass = (err_cnt==0), drive gate_a/gate_b to 0, and return to IDLE.
REQ-020 SHALL make the first done pulse occur 4*(D+1)+1 cycles after the cycle start is sampled.
REQ-021 SHALL ignore start while busy or in DONE.
REQ-022 SHALL treat dwell=0 as dwell=1.
REQ-023 SHALL hold err_cnt, pass and fail_vec stable from DONE until the next accepted start.
REQ-024 SHALL hold fail_vec at 0 when err_cnt=0.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE and gate_a, gate_b, busy, done, pass, err_cnt, fail_vec, and the dwell counter to 0, including mid-sweep.
REQ-026 SHALL resume operation on the first clk edge after rst_n deasserts, accepting start only from IDLE.

Configuration
REQ-027 SHALL support the macro GATE_SEQ_LOOP_EN.
REQ-028 SHALL, with GATE_SEQ_LOOP_EN defined, add input stop (1 bit) and, after DONE, restart at vector 0 without returning through IDLE unless stop was sampled high during the sweep.
REQ-029 SHALL, in loop mode, clear err_cnt and fail_vec at each restart; done still pulses once per sweep.
REQ-030 SHALL, without GATE_SEQ_LOOP_EN, have no stop port and perform exactly one sweep per start.

Structure
REQ-031 SHALL place the following in shared package gate_seq_pkg: the state type, NUM_VEC=4, and the expected-output function (XOR).
REQ-032 SHALL place the dwell down-counter in sub-module gate_seq_timer (load, count-down, zero flag).

Verification
REQ-033 SHALL verify a correct XOR gate with dwell=3: vectors change every 4 cycles, done at cycle 17 after start, pass=1, err_cnt=0.
REQ-034 SHALL verify gate_y stuck at 0: err_cnt=2, fail_vec=1, pass=0.
REQ-035 SHALL verify an XNOR substituted for the gate: err_cnt=4, fail_vec=0, pass=0.
REQ-036 SHALL verify dwell=0: each vector is held 2 cycles and done occurs at cycle 9.
REQ-037 SHALL verify start pulsed mid-sweep: no restart and an unchanged done time; rst_n pulsed low mid-sweep: all outputs 0 asynchronously and next start runs a full sweep.
REQ-038 SHALL verify, with GATE_SEQ_LOOP_EN: two consecutive sweeps with two done pulses; stop asserted in the second sweep returns to IDLE after its DONE.
